// File: rtl/onehot_prepro_pkg.sv
// Shared types and helpers for the sliced one-hot operand preprocessor.
package onehot_prepro_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // Popcount saturates here: only 0, 1 and "more than one" matter.
  localparam int CNT_SAT = 2;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/prepro_chunk_scan.sv
// Combinational slice scanner: saturated popcount (0/1/2) and lowest set-bit position.
module prepro_chunk_scan
  import onehot_prepro_pkg::*;
#(
  parameter int CHUNK = 8,
  localparam int LW = (CHUNK > 1) ? clog2(CHUNK) : 1
) (
  input  logic [CHUNK-1:0] slice,
  output logic [1:0]       sat_cnt,
  output logic [LW-1:0]    local_idx
);

  // A slice holds at most CHUNK ones, so this sum cannot overflow.
  localparam int SW = clog2(CHUNK + 1);

  logic [SW-1:0] ones;

  always_comb begin
    ones      = '0;
    local_idx = '0;
    for (int i = CHUNK - 1; i >= 0; i--) begin
      ones = ones + SW'(slice[i]);
      if (slice[i]) local_idx = LW'(i);
    end
    sat_cnt = (int'(ones) >= CNT_SAT) ? 2'(CNT_SAT) : 2'(ones);
  end

endmodule

// File: rtl/onehot_prepro_seq.sv
// Multi-cycle one-hot operand preprocessor: scans WIDTH/CHUNK slices LSB first,
// fixed latency N+1 from the accepting edge, start ignored while busy or done.
module onehot_prepro_seq
  import onehot_prepro_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8,
  localparam int IDXW = clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             onehot,
  output logic             zero,
  output logic [IDXW-1:0]  index
);

  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? clog2(N) : 1;
  localparam int LW = (CHUNK > 1) ? clog2(CHUNK) : 1;

  state_t state, state_nxt;

  logic [WIDTH-1:0] op_q;
  logic [KW-1:0]    k;
  logic [1:0]       cnt;
  logic [IDXW-1:0]  idx_q;

  logic [CHUNK-1:0] slice;
  logic [1:0]       slice_cnt;
  logic [LW-1:0]    local_idx;
  logic             last;
  logic [2:0]       cnt_sum;
  logic [1:0]       cnt_nxt;
  logic [IDXW-1:0]  idx_nxt;

  assign slice = op_q[k*CHUNK +: CHUNK];
  assign last  = (int'(k) == N - 1);

  prepro_chunk_scan #(.CHUNK(CHUNK)) u_scan (
    .slice     (slice),
    .sat_cnt   (slice_cnt),
    .local_idx (local_idx)
  );

  // Only the first lone bit ever seen is a candidate; later bits make cnt >= 2 anyway.
  always_comb begin
    cnt_sum = {1'b0, cnt} + {1'b0, slice_cnt};
    cnt_nxt = (int'(cnt_sum) >= CNT_SAT) ? 2'(CNT_SAT) : cnt_sum[1:0];
    idx_nxt = idx_q;
    if (slice_cnt == 2'd1 && cnt == 2'd0)
      idx_nxt = IDXW'(int'(k) * CHUNK + int'(local_idx));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SCAN;
      SCAN:    if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == SCAN);
    done = (state == DONE);
  end

  // Results load on the edge entering DONE and hold until the next completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q   <= '0;
      k      <= '0;
      cnt    <= '0;
      idx_q  <= '0;
      out    <= '0;
      onehot <= 1'b0;
      zero   <= 1'b0;
      index  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q  <= b;
            k     <= '0;
            cnt   <= '0;
            idx_q <= '0;
          end
        end
        SCAN: begin
          cnt   <= cnt_nxt;
          idx_q <= idx_nxt;
          k     <= last ? '0 : k + 1'b1;
          if (last) begin
            out    <= (cnt_nxt <= 2'd1) ? op_q : '0;
            onehot <= (cnt_nxt == 2'd1);
            zero   <= (cnt_nxt == 2'd0);
            index  <= (cnt_nxt == 2'd1) ? idx_nxt : '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_onehot_prepro_seq.sv
// Bench for onehot_prepro_seq: vector table, corner sequences, chunk sweep and random ops vs a popcount model.
module tb_onehot_prepro_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance 0: CHUNK=8 (N=4), 1: CHUNK=32 (N=1), 2: CHUNK=1 (N=32)
  logic [2:0]  start_v = '0;
  logic [2:0]  busy_v, done_v, onehot_v, zero_v;
  logic [31:0] b_v   [3] = '{32'd0, 32'd0, 32'd0};
  logic [31:0] out_v [3];
  logic [4:0]  idx_v [3];

  onehot_prepro_seq #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .rst(rst), .start(start_v[0]), .b(b_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .out(out_v[0]), .onehot(onehot_v[0]), .zero(zero_v[0]), .index(idx_v[0]));
  onehot_prepro_seq #(.WIDTH(32), .CHUNK(32)) dut_c32 (
    .clk(clk), .rst(rst), .start(start_v[1]), .b(b_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .out(out_v[1]), .onehot(onehot_v[1]), .zero(zero_v[1]), .index(idx_v[1]));
  onehot_prepro_seq #(.WIDTH(32), .CHUNK(1)) dut_c1 (
    .clk(clk), .rst(rst), .start(start_v[2]), .b(b_v[2]), .busy(busy_v[2]), .done(done_v[2]),
    .out(out_v[2]), .onehot(onehot_v[2]), .zero(zero_v[2]), .index(idx_v[2]));

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt [3] = '{0, 0, 0};
  int overlap  = 0;
  int lat_exp  [3] = '{5, 2, 33};

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (done_v[i]) done_cnt[i] = done_cnt[i] + 1;
      if (done_v[i] && busy_v[i]) overlap = overlap + 1;
    end
  end

  typedef struct {
    logic [31:0] out;
    logic        onehot;
    logic        zero;
    logic [4:0]  index;
  } res_t;

  typedef struct {
    logic [31:0] b;
    logic [31:0] out;
    logic        onehot;
    logic        zero;
    logic [4:0]  index;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: defined purely from the popcount of the whole operand.
  function automatic res_t model(input logic [31:0] v);
    res_t r;
    int pc;
    pc       = $countones(v);
    r.out    = (pc <= 1) ? v : 32'd0;
    r.onehot = (pc == 1);
    r.zero   = (pc == 0);
    r.index  = '0;
    if (pc == 1)
      for (int i = 0; i < 32; i++) if (v[i]) r.index = 5'(i);
    return r;
  endfunction

  task automatic wait_idle(input int d);
    int guard;
    guard = 0;
    while ((busy_v[d] || done_v[d]) && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
  endtask

  // Returns cycles from accepting edge to the done cycle, and busy cycles seen.
  task automatic run_op(input int d, input logic [31:0] val, output int lat, output int bcyc);
    wait_idle(d);
    @(negedge clk);
    start_v[d] = 1'b1;
    b_v[d]     = val;
    @(posedge clk); #1;
    start_v[d] = 1'b0;
    b_v[d]     = $urandom;
    lat  = 1;
    bcyc = 0;
    while (!done_v[d] && lat < 100) begin
      if (busy_v[d]) bcyc++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic check_res(input string tag, input int d, input res_t e);
    check({tag, " out"},    out_v[d],    e.out);
    check({tag, " onehot"}, onehot_v[d], 32'(e.onehot));
    check({tag, " zero"},   zero_v[d],   32'(e.zero));
    check({tag, " index"},  idx_v[d],    32'(e.index));
  endtask

  initial begin
    vec_t vecs [7];
    res_t e;
    int lat, bc, dc, cycles, last_done, found;
    logic [31:0] ops  [3];
    logic [31:0] bops [3];
    logic [4:0]  bidx [3];
    logic        boh  [3];
    logic [31:0] rv;

    vecs[0] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 5'd0};
    vecs[1] = '{32'h0000_0400, 32'h0000_0400, 1'b1, 1'b0, 5'd10};
    vecs[2] = '{32'h8000_0001, 32'h0000_0000, 1'b0, 1'b0, 5'd0};
    vecs[3] = '{32'h0000_0003, 32'h0000_0000, 1'b0, 1'b0, 5'd0};
    vecs[4] = '{32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 5'd31};
    vecs[5] = '{32'h0010_0000, 32'h0010_0000, 1'b1, 1'b0, 5'd20};
    vecs[6] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0, 5'd0};

    // Reset state
    #12;
    check("rst busy",   busy_v[0],   0);
    check("rst done",   done_v[0],   0);
    check("rst out",    out_v[0],    0);
    check("rst onehot", onehot_v[0], 0);
    check("rst zero",   zero_v[0],   0);
    check("rst index",  idx_v[0],    0);
    @(negedge clk);
    rst = 1'b0;

    // Vector table
    for (int i = 0; i < 7; i++) begin
      run_op(0, vecs[i].b, lat, bc);
      check($sformatf("vec%0d latency", i), lat, 5);
      check($sformatf("vec%0d busy cycles", i), bc, 4);
      check($sformatf("vec%0d busy in done", i), busy_v[0], 0);
      e = '{vecs[i].out, vecs[i].onehot, vecs[i].zero, vecs[i].index};
      check_res($sformatf("vec%0d", i), 0, e);
    end

    // start during SCAN is ignored
    wait_idle(0);
    @(negedge clk);
    start_v[0] = 1'b1; b_v[0] = 32'h4;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    dc = done_cnt[0];
    @(negedge clk);
    start_v[0] = 1'b1; b_v[0] = 32'h10;
    @(negedge clk);
    start_v[0] = 1'b0;
    cycles = 0;
    while (!done_v[0] && cycles < 50) begin @(posedge clk); #1; cycles++; end
    check("ign done seen", done_v[0], 1);
    check_res("ign", 0, '{32'h4, 1'b1, 1'b0, 5'd2});
    repeat (10) @(posedge clk);
    check("ign done count", done_cnt[0] - dc, 1);

    // Reset mid-SCAN aborts without a done pulse
    wait_idle(0);
    @(negedge clk);
    start_v[0] = 1'b1; b_v[0] = 32'h400;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    @(posedge clk); #3;
    dc = done_cnt[0];
    rst = 1'b1;
    #1;
    check("abort busy",   busy_v[0],   0);
    check("abort done",   done_v[0],   0);
    check_res("abort", 0, '{32'h0, 1'b0, 1'b0, 5'd0});
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("abort no done", done_cnt[0] - dc, 0);
    run_op(0, 32'h100, lat, bc);
    check("post-rst latency", lat, 5);
    check_res("post-rst", 0, '{32'h100, 1'b1, 1'b0, 5'd8});

    // Chunk-size sweep
    for (int d = 1; d < 3; d++) begin
      run_op(d, 32'h8000_0000, lat, bc);
      check($sformatf("sweep%0d latency", d), lat, lat_exp[d]);
      check($sformatf("sweep%0d busy cycles", d), bc, lat_exp[d] - 1);
      check_res($sformatf("sweep%0d", d), d, '{32'h8000_0000, 1'b1, 1'b0, 5'd31});
    end

    // Back-to-back with start held high
    ops  = '{32'h1, 32'h6, 32'h40};
    bops = '{32'h1, 32'h0, 32'h40};
    bidx = '{5'd0, 5'd0, 5'd6};
    boh  = '{1'b1, 1'b0, 1'b1};
    wait_idle(0);
    @(negedge clk);
    start_v[0] = 1'b1; b_v[0] = ops[0];
    cycles = 0; found = 0; last_done = 0;
    while (found < 3 && cycles < 100) begin
      @(posedge clk); #1;
      cycles++;
      if (done_v[0]) begin
        check_res($sformatf("b2b%0d", found), 0, '{bops[found], boh[found], 1'b0, bidx[found]});
        if (found > 0) check($sformatf("b2b%0d spacing", found), cycles - last_done, 6);
        last_done = cycles;
        found++;
        if (found < 3) b_v[0] = ops[found];
        else start_v[0] = 1'b0;
      end
    end
    start_v[0] = 1'b0;
    check("b2b done count", found, 3);

    // Random operands against the model
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       rv = 32'd0;
        1:       rv = 32'd1 << $urandom_range(0, 31);
        2:       rv = (32'd1 << $urandom_range(0, 31)) | (32'd1 << $urandom_range(0, 31));
        default: rv = $urandom;
      endcase
      run_op(i % 2, rv, lat, bc);
      check($sformatf("rand%0d latency", i), lat, lat_exp[i % 2]);
      check_res($sformatf("rand%0d b=%0h", i, rv), i % 2, model(rv));
    end

    repeat (3) @(posedge clk);
    check("done/busy overlap", overlap, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
